ahb_arbiter_rr: RTL and testbench

//   Parametrised AHB bus arbiter, successor to the fixed 16-master arbiter. Selects one bus master per

---
 rtl/ahb_arb_pkg.sv | 24 ++
 rtl/ahb_rr_picker.sv | 32 +++
 rtl/ahb_arbiter_rr.sv | 103 ++++++++++
 tb/tb_ahb_arbiter_rr.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the parametrised AHB arbiter.
package ahb_arb_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  localparam int ARB_MAX_MASTERS = 16;

  // Master index width; a two-master bus still needs one bit.
  function automatic int arb_mw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [$clog2(ARB_MAX_MASTERS)-1:0] onehot2idx(
    input logic [ARB_MAX_MASTERS-1:0] oh
  );
    logic [$clog2(ARB_MAX_MASTERS)-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | ($clog2(ARB_MAX_MASTERS))'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority picker: first set request scanning upward from start_i+1, wrapping.
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int MW = arb_mw(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [MW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic          found;
  logic [MW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = MW'((int'(start_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter: fixed-priority or round-robin grant with lock, SPLIT masking and bounded tenure.
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 1,
  parameter int MAX_HOLD       = 16,
  localparam int MW = arb_mw(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic                   HSPLITRESP,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam int TW = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [TW-1:0]          TMAX       = TW'(MAX_HOLD - 1);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IX = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
  logic [TW-1:0]          tenure_q, tenure_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [MW-1:0]          hmaster_q;
  logic                   hmastlock_q;

  logic [MW-1:0]          holder;
  logic [NUM_MASTERS-1:0] eligible, others, pick_gnt;
  logic                   pick_valid;
  logic [MW-1:0]          pick_start;

  // Split set from the current address-phase owner wins over a same-cycle release.
  assign split_mask_d = (split_mask_q & ~HSPLIT)
                      | (HSPLITRESP ? (NUM_MASTERS'(1) << hmaster_q) : '0);

  assign holder     = MW'(onehot2idx(ARB_MAX_MASTERS'(grant_q)));
  assign eligible   = HBUSREQx & ~split_mask_d;
  assign others     = eligible & ~grant_q;
  assign pick_start = (ARB_MODE == int'(ARB_RR)) ? rr_ptr_q : MW'(NUM_MASTERS - 1);

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i   (others),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // HREADY=1 closes the current transfer; grant, tenure and pointer only move on such edges.
  always_comb begin
    grant_d  = grant_q;
    tenure_d = tenure_q;
    rr_ptr_d = rr_ptr_q;
    if (HREADY) begin
      if (HLOCKx[holder] && !split_mask_d[holder]) begin
        grant_d = grant_q;
      end else if (eligible[holder] && ((tenure_q < TMAX) || !pick_valid)) begin
        tenure_d = (tenure_q == TMAX) ? tenure_q : tenure_q + TW'(1);
      end else if (pick_valid) begin
        grant_d  = pick_gnt;
        tenure_d = '0;
        rr_ptr_d = MW'(onehot2idx(ARB_MAX_MASTERS'(pick_gnt)));
      end else begin
        grant_d  = DEFAULT_OH;
        tenure_d = '0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q      <= DEFAULT_OH;
      split_mask_q <= '0;
      tenure_q     <= '0;
      rr_ptr_q     <= DEFAULT_IX;
      hmaster_q    <= DEFAULT_IX;
      hmastlock_q  <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      split_mask_q <= split_mask_d;
      tenure_q     <= tenure_d;
      rr_ptr_q     <= rr_ptr_d;
      if (HREADY) begin
        hmaster_q   <= holder;
        hmastlock_q <= HLOCKx[holder];
      end
    end
  end

  assign HGRANTx   = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANTx));

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: a round-robin and a fixed-priority instance driven by shared stimulus.
module tb_ahb_arbiter_rr;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXH = 4;
  localparam int MW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req, lock, split;
  logic          splitresp, hready;
  logic [N-1:0]  gnt_rr, gnt_fx;
  logic [MW-1:0] hm_rr, hm_fx;
  logic          ml_rr, ml_fx;

  ahb_arbiter_rr #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .ARB_MODE(1), .MAX_HOLD(MAXH)) dut_rr (
    .HCLK(clk), .HRESET(rst), .HBUSREQx(req), .HLOCKx(lock), .HSPLIT(split),
    .HSPLITRESP(splitresp), .HREADY(hready), .HGRANTx(gnt_rr), .HMASTER(hm_rr), .HMASTLOCK(ml_rr)
  );

  ahb_arbiter_rr #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .ARB_MODE(0), .MAX_HOLD(MAXH)) dut_fx (
    .HCLK(clk), .HRESET(rst), .HBUSREQx(req), .HLOCKx(lock), .HSPLIT(split),
    .HSPLITRESP(splitresp), .HREADY(hready), .HGRANTx(gnt_fx), .HMASTER(hm_fx), .HMASTLOCK(ml_fx)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (index 0 = fixed, 1 = round-robin) ----------------
  int           m_holder[2], m_tenure[2], m_ptr[2], m_master[2];
  bit           m_lock[2];
  bit [N-1:0]   m_mask[2];

  function automatic bit bit_at(input bit [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int choose(input int k, input bit [N-1:0] elig, input int h);
    int w;
    w = -1;
    if (k == 1) begin
      for (int d = 1; d <= N; d++) begin
        int c;
        c = (m_ptr[k] + d) % N;
        if (w < 0 && c != h && bit_at(elig, c)) w = c;
      end
    end else begin
      for (int c = N - 1; c >= 0; c--) if (c != h && bit_at(elig, c)) w = c;
    end
    return w;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit [N-1:0] mnew, elig;
      int h, w;
      mnew = m_mask[k] & ~split;
      if (splitresp) mnew = mnew | (N'(1) << m_master[k]);
      if (rst) begin
        m_holder[k] = DEF; m_master[k] = DEF; m_lock[k] = 1'b0;
        m_mask[k] = '0; m_tenure[k] = 0; m_ptr[k] = DEF;
      end else begin
        if (hready) begin
          h    = m_holder[k];
          elig = req & ~mnew;
          w    = choose(k, elig, h);
          if (bit_at(lock, h) && !bit_at(mnew, h)) begin
            // locked owner stays, tenure frozen
          end else if (bit_at(elig, h) && (m_tenure[k] < MAXH - 1 || w < 0)) begin
            if (m_tenure[k] < MAXH - 1) m_tenure[k]++;
          end else if (w >= 0) begin
            m_holder[k] = w; m_tenure[k] = 0; m_ptr[k] = w;
          end else begin
            m_holder[k] = DEF; m_tenure[k] = 0;
          end
          m_master[k] = h;
          m_lock[k]   = bit_at(lock, h);
        end
        m_mask[k] = mnew;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("gnt_fx", gnt_fx, N'(1) << m_holder[0]);
    check("hm_fx",  hm_fx,  m_master[0]);
    check("ml_fx",  ml_fx,  m_lock[0]);
    check("gnt_rr", gnt_rr, N'(1) << m_holder[1]);
    check("hm_rr",  hm_rr,  m_master[1]);
    check("ml_rr",  ml_rr,  m_lock[1]);
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; split = '0; splitresp = 1'b0; hready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;

    // Reset then idle: default master owns the bus.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_idle_gnt", gnt_rr, 4'b0001);
      check("rst_idle_hm",  hm_rr,  2'd0);
      check("rst_idle_ml",  ml_rr,  1'b0);
    end

    // Round-robin with 1110 held: 1,2,3 for four cycles each, then wrap to 1.
    do_reset();
    req = 4'b1110;
    for (int k = 0; k < 13; k++) exp_q.push_back(N'(1) << (((k / 4) % 3) + 1));
    for (int k = 0; k < 13; k++) begin
      tick();
      check("rr_seq", gnt_rr, exp_q.pop_front());
    end

    // Fixed priority with 0110 and a three-cycle stall mid-tenure.
    do_reset();
    req = 4'b0110;
    exp_q = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    for (int k = 0; k < 12; k++) begin
      hready = !(k >= 2 && k <= 4);
      tick();
      check("fx_seq", gnt_fx, exp_q.pop_front());
      if (k >= 2 && k <= 4) check("fx_stall_hm", hm_fx, 2'd1);
    end
    hready = 1'b1;

    // Locked master 2 keeps the bus against master 1.
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    tick();
    check("lock_gnt", gnt_rr, 4'b0100);
    check("lock_ml_lag", ml_rr, 1'b0);
    req = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("lock_hold", gnt_rr, 4'b0100);
      check("lock_ml", ml_rr, 1'b1);
    end
    req = 4'b0010; lock = 4'b0000;
    tick();
    check("lock_release", gnt_rr, 4'b0010);
    check("lock_release_fx", gnt_fx, 4'b0010);

    // Split: master 3 masked while requesting, then released; reset mid-burst.
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    check("split_hm", hm_rr, 2'd3);
    splitresp = 1'b1;
    tick();
    splitresp = 1'b0;
    check("split_drop", gnt_rr, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("split_masked", gnt_rr, 4'b0001);
    end
    split = 4'b1000;
    tick();
    split = 4'b0000;
    check("split_release", gnt_rr, 4'b1000);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_gnt", gnt_rr, 4'b0001);
    check("midrst_hm",  hm_rr,  2'd0);
    rst = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      req       = N'($urandom_range(0, 15));
      lock      = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      split     = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
      splitresp = ($urandom_range(0, 9) == 0);
      hready    = ($urandom_range(0, 4) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
